// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and counter sizing for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter must index 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_bit.sv
// rtl/serial_adder_bit.sv - combinational one-bit full adder cell
module serial_adder_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a | b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready handshakes
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic             msb_cin;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             step;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_nx;

    assign last_bit = (cnt == LAST);

    // The single full-adder cell sees the current LSBs and the running carry.
    serial_adder_bit u_bit (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c  (carry),
        .s  (sum_bit),
        .co (carry_nx)
    );

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake decode; inputs outside the owning state are ignored.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then one bit per edge; sum enters from the MSB end.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= ci;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= {sum_bit, s_sr[WIDTH-1:1]};
            carry <= carry_nx;
            if (last_bit) begin
                // Carry entering the MSB cell, kept for signed overflow.
                msb_cin <= carry;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign s   = s_sr;
    assign co  = carry;
    assign ovf = msb_cin ^ carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         ck;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         busy;

    int vectors    = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(W)) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference: {ovf, co, s} from plain integer addition and sign rules.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'd0, c};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t};
    endfunction

    task automatic step_clk();
        @(posedge ck);
        #1;
    endtask

    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a        = av;
        b        = bv;
        ci       = cv;
        in_valid = 1'b1;
        step_clk();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            step_clk();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        repeat (2) step_clk();
        rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, s, co, ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b s=%h co=%b ovf=%b required rdy=1 vld=0 busy=0 s=00 co=0 ovf=0",
                     in_ready, out_valid, busy, s, co, ovf);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'h7F};
        logic [7:0] tb [3] = '{8'hA5, 8'h01, 8'h00};
        logic       tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] te [3] = '{{1'b0, 1'b0, 8'hFF}, {1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], tc[i]);
            vectors++;
            if ({busy, in_ready} !== 2'b10) begin
                miscompares++;
                $display("FAIL shift_flags[%0d]: busy=%b rdy=%b required busy=1 rdy=0", i, busy, in_ready);
            end
            wait_valid(cyc);
            vectors++;
            if (cyc !== W) begin
                miscompares++;
                $display("FAIL latency[%0d]: %0d edges required %0d", i, cyc, W);
            end
            vectors++;
            if ({ovf, co, s} !== te[i]) begin
                miscompares++;
                $display("FAIL directed[%0d]: ovf=%b co=%b s=%h required ovf=%b co=%b s=%h",
                         i, ovf, co, s, te[i][9], te[i][8], te[i][7:0]);
            end
            out_ready = 1'b1;
            step_clk();
            out_ready = 1'b0;
            vectors++;
            if ({out_valid, in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL consume[%0d]: vld=%b rdy=%b required vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp;
        int cyc;
        exp = model(8'h3C, 8'h4D, 1'b1);
        start_op(8'h3C, 8'h4D, 1'b1);
        wait_valid(cyc);
        // Offer a new operand set during DONE; it must be ignored, including on the consume edge.
        a        = 8'hEE;
        b        = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({out_valid, in_ready, ovf, co, s} !== {1'b1, 1'b0, exp}) begin
                miscompares++;
                $display("FAIL hold[%0d]: vld=%b rdy=%b ovf=%b co=%b s=%h required vld=1 rdy=0 ovf=%b co=%b s=%h",
                         i, out_valid, in_ready, ovf, co, s, exp[9], exp[8], exp[7:0]);
            end
            step_clk();
        end
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL no_accept_on_consume: vld=%b busy=%b rdy=%b required vld=0 busy=0 rdy=1",
                     out_valid, busy, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_ignore_inputs();
        logic [9:0] exp;
        exp = model(8'hC3, 8'h96, 1'b1);
        a        = 8'hC3;
        b        = 8'h96;
        ci       = 1'b1;
        in_valid = 1'b1;
        step_clk();
        for (int i = 0; i < W; i++) begin
            a         = 8'($urandom);
            b         = 8'($urandom);
            ci        = 1'($urandom);
            out_ready = (i < W - 1) ? 1'b1 : 1'b0;
            step_clk();
        end
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, ovf, co, s} !== {1'b1, exp}) begin
            miscompares++;
            $display("FAIL ignore_inputs: vld=%b ovf=%b co=%b s=%h required vld=1 ovf=%b co=%b s=%h",
                     out_valid, ovf, co, s, exp[9], exp[8], exp[7:0]);
        end
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midshift();
        int cyc;
        start_op(8'h33, 8'h44, 1'b0);
        repeat (4) step_clk();
        rst = 1'b1;
        #2;
        vectors++;
        if ({out_valid, busy, s, co, ovf} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_async: vld=%b busy=%b s=%h co=%b ovf=%b required all 0",
                     out_valid, busy, s, co, ovf);
        end
        step_clk();
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: rdy=%b required 1", in_ready);
        end
        start_op(8'h10, 8'h20, 1'b0);
        wait_valid(cyc);
        vectors++;
        if ({cyc, ovf, co, s} !== {W, 10'h030}) begin
            miscompares++;
            $display("FAIL after_reset: cyc=%0d ovf=%b co=%b s=%h required cyc=%0d ovf=0 co=0 s=30",
                     cyc, ovf, co, s, W);
        end
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [9:0] exp;
        int         cyc;
        int         guard;
        logic       taken;
        for (int n = 0; n < 4000; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            exp = model(ra, rb, rc);
            repeat ($urandom_range(0, 2)) step_clk();
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: rdy=%b required 1", n, in_ready);
            end
            start_op(ra, rb, rc);
            wait_valid(cyc);
            vectors++;
            if ({cyc, out_valid, ovf, co, s} !== {W, 1'b1, exp}) begin
                miscompares++;
                $display("FAIL rand[%0d]: %h+%h+%b cyc=%0d vld=%b ovf=%b co=%b s=%h required cyc=%0d vld=1 ovf=%b co=%b s=%h",
                         n, ra, rb, rc, cyc, out_valid, ovf, co, s, W, exp[9], exp[8], exp[7:0]);
            end
            taken = 1'b0;
            guard = 0;
            while (!taken && guard < 50) begin
                out_ready = 1'($urandom);
                taken     = out_ready && out_valid;
                step_clk();
                guard++;
            end
            out_ready = 1'b0;
            if (!taken) begin
                vectors++;
                miscompares++;
                $display("FAIL rand_drain[%0d]: result not consumed within 50 cycles", n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_inputs();
        test_reset_midshift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
